imm_ext_assembler: RTL

- Parametrised fetch-side splitter between instruction fetch and decode.
- Registers each fetched word and classifies it as an opcode word or an immediate extension word.
- An opcode word with the immediate flag set is followed by 1..MAX_EXT extension words. Each extension word is replaced by a bubble instruction carrying the opcode's destination field, so the forwarding logic can deliver the immediate.
- Extension words are assembled into a wide immediate. Supports flush on jump/branch and a pipeline stall.

---
 rtl/imm_ext_assembler_if.sv | 27 ++
 rtl/imm_ext_assembler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/imm_ext_assembler_if.sv
// Fetch-to-decode bus for imm_ext_assembler: fetched word, flow control and
// the decoded instruction/immediate stream.
interface imm_ext_assembler_if #(
  parameter int WORD_W  = 16,
  parameter int MAX_EXT = 2
);
  logic [WORD_W-1:0]         ir_in;
  logic                      ir_valid;
  logic                      flush;
  logic                      stall;
  logic [WORD_W-1:0]         instruction;
  logic [WORD_W*MAX_EXT-1:0] immediate;
  logic                      out_valid;
  logic                      bubble;
  logic                      imm_done;
  logic                      busy;

  modport master (
    output ir_in, ir_valid, flush, stall,
    input  instruction, immediate, out_valid, bubble, imm_done, busy
  );

  modport slave (
    input  ir_in, ir_valid, flush, stall,
    output instruction, immediate, out_valid, bubble, imm_done, busy
  );
endinterface

// File: rtl/imm_ext_assembler.sv
// Splits fetched words into opcodes and immediate extension words, replacing
// each extension word by a bubble. Optional macro IMM_SIGN_EXT_EN sign-fills unused slices.
module imm_ext_assembler #(
  parameter int WORD_W       = 16,
  parameter int MAX_EXT      = 2,
  parameter int IMM_FLAG_BIT = 2,
  parameter int LEN_LSB      = 0,
  parameter int DST_LSB      = 3,
  parameter int DST_W        = 4,
  parameter logic [WORD_W-1:0] BUBBLE_OP = 16'h07F8
) (
  input logic             clk,
  input logic             rst,
  imm_ext_assembler_if.slave bus
);
  localparam int LEN_W  = $clog2(MAX_EXT);
  localparam int LEN_WS = (LEN_W < 1) ? 1 : LEN_W;
  localparam int CNT_W  = $clog2(MAX_EXT + 1);
  localparam int IMM_W  = WORD_W * MAX_EXT;

  typedef enum logic {IDLE, EXT} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_rem, w_rem_next;
  logic [CNT_W-1:0]   r_n, w_n_next;
  logic [DST_W-1:0]   r_dst, w_dst_next;
  logic [WORD_W-1:0]  r_instr_p1, w_instr_next;
  logic [IMM_W-1:0]   r_imm_p1, w_imm_next;
  logic               r_vld_p1, w_vld_next;
  logic               r_bub_p1, w_bub_next;
  logic               r_done_p1, w_done_next;
  logic [CNT_W-1:0]   w_k;
  logic [IMM_W-1:0]   w_imm_upd;

  // With MAX_EXT=1 there is no length field; the slice read is simply ignored.
  function automatic logic [CNT_W-1:0] ext_count(input logic [WORD_W-1:0] w);
    logic [LEN_WS:0] n;
    n = {1'b0, w[LEN_LSB +: LEN_WS]} + (LEN_WS+1)'(1);
    if (MAX_EXT == 1)       return CNT_W'(1);
    if (int'(n) > MAX_EXT)  return CNT_W'(MAX_EXT);
    return CNT_W'(n);
  endfunction

  function automatic logic [WORD_W-1:0] bubble_word(input logic [DST_W-1:0] dst);
    logic [WORD_W-1:0] b;
    b = BUBBLE_OP;
    b[DST_LSB +: DST_W] = dst;
    return b;
  endfunction

  function automatic logic [IMM_W-1:0] sign_fill(input logic [IMM_W-1:0] imm,
                                                 input logic [CNT_W-1:0] last,
                                                 input logic             msb);
    logic [IMM_W-1:0] r;
    r = imm;
    for (int j = 0; j < MAX_EXT; j++)
      if (CNT_W'(j) > last) r[j*WORD_W +: WORD_W] = {WORD_W{msb}};
    return r;
  endfunction

  // Slice index of the current extension word within its sequence.
  always_comb begin
    w_k       = r_n - r_rem;
    w_imm_upd = r_imm_p1;
    for (int j = 0; j < MAX_EXT; j++)
      if (CNT_W'(j) == w_k) w_imm_upd[j*WORD_W +: WORD_W] = bus.ir_in;
  end

  always_comb begin
    w_state_next = r_state;
    w_rem_next   = r_rem;
    w_n_next     = r_n;
    w_dst_next   = r_dst;
    w_instr_next = r_instr_p1;
    w_imm_next   = r_imm_p1;
    w_vld_next   = 1'b0;
    w_bub_next   = 1'b0;
    w_done_next  = 1'b0;
    if (bus.stall) begin
      w_vld_next  = r_vld_p1;
      w_bub_next  = r_bub_p1;
      w_done_next = r_done_p1;
    end else if (bus.ir_valid) begin
      w_vld_next = 1'b1;
      if (r_state == EXT && !bus.flush) begin
        w_instr_next = bubble_word(r_dst);
        w_bub_next   = 1'b1;
        w_imm_next   = w_imm_upd;
        w_rem_next   = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
`ifdef IMM_SIGN_EXT_EN
          w_imm_next   = sign_fill(w_imm_upd, w_k, bus.ir_in[WORD_W-1]);
`endif
        end
      end else begin
        // Flush abandons a pending sequence; the word is treated as an opcode.
        w_instr_next = bus.ir_in;
        w_state_next = IDLE;
        w_rem_next   = '0;
        if (bus.ir_in[IMM_FLAG_BIT]) begin
          w_dst_next   = bus.ir_in[DST_LSB +: DST_W];
          w_n_next     = ext_count(bus.ir_in);
          w_rem_next   = ext_count(bus.ir_in);
          w_imm_next   = '0;
          w_state_next = EXT;
        end
      end
    end
  end

  // Output stage _p1: one cycle after ir_in is sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_n        <= '0;
      r_dst      <= '0;
      r_instr_p1 <= '0;
      r_imm_p1   <= '0;
      r_vld_p1   <= 1'b0;
      r_bub_p1   <= 1'b0;
      r_done_p1  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rem      <= w_rem_next;
      r_n        <= w_n_next;
      r_dst      <= w_dst_next;
      r_instr_p1 <= w_instr_next;
      r_imm_p1   <= w_imm_next;
      r_vld_p1   <= w_vld_next;
      r_bub_p1   <= w_bub_next;
      r_done_p1  <= w_done_next;
    end
  end

  assign bus.instruction = r_instr_p1;
  assign bus.immediate   = r_imm_p1;
  assign bus.out_valid   = r_vld_p1;
  assign bus.bubble      = r_bub_p1;
  assign bus.imm_done    = r_done_p1;
  assign bus.busy        = (r_state == EXT);
endmodule
